pipelined_bypass_subtractor: RTL and testbench

- Pipelined carry-bypass subtractor: computes DIFF = A - B - BIN on WIDTH-bit operands.
- Subtraction is done as A + ~B + ~BIN, using 4-bit segments with segment-level carry bypass.
- Datapath is split across STAGES register stages, so throughput is one result per cycle.
- Feeds downstream ALU consumers through a valid/ready handshake.

---
 rtl/pipelined_bypass_subtractor_pkg.sv | 20 ++
 rtl/pipelined_bypass_subtractor_segment.sv | 30 +++
 rtl/pipelined_bypass_subtractor.sv | 124 ++++++++++++
 tb/tb_pipelined_bypass_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_bypass_subtractor_pkg.sv
// Shared definitions for the pipelined carry-bypass subtractor: segment width,
// per-stage control payload and the stage slice width helper.
package pipelined_bypass_subtractor_pkg;

  localparam int SEG_W_DEF = 4;

  // Control half of a stage payload; the operand and diff slices are sized by
  // the instantiating module because they depend on WIDTH.
  typedef struct packed {
    logic vld;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctl_t;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_bypass_subtractor_segment.sv
// One carry-bypass segment: ripple full adders on a and ~b, with the carry-in
// forwarded straight to the carry-out when every bit position propagates.
module bypass_sub_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] nb,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  logic p_seg;
  logic ripple_co;

  always_comb begin
    logic cy;
    cy  = cin;
    sum = '0;
    for (int i = 0; i < SEG_W; i++) begin
      sum[i] = a[i] ^ nb[i] ^ cy;
      cy     = (a[i] & nb[i]) | (cy & (a[i] ^ nb[i]));
    end
    ripple_co = cy;
  end

  assign p_seg = &(a ^ nb);
  assign cout  = p_seg ? cin : ripple_co;

endmodule

// File: rtl/pipelined_bypass_subtractor.sv
// Pipelined carry-bypass subtractor: diff = a - b - bin computed as a + ~b + ~bin,
// one WIDTH/STAGES slice per register stage, with a global valid/ready stall.
module pipelined_bypass_subtractor
  import pipelined_bypass_subtractor_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int SEG_W  = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int SW   = slice_w(WIDTH, STAGES);
  localparam int NSEG = SW / SEG_W;
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST = STAGES - 1;

  logic advance;

  stage_ctl_t       ctl_p  [NREG];
  logic [WIDTH-1:0] a_p    [NREG];
  logic [WIDTH-1:0] nb_p   [NREG];
  logic [WIDTH-1:0] diff_p [NREG];

  logic             vld_in  [STAGES];
  logic             c_in    [STAGES];
  logic             am_in   [STAGES];
  logic             bm_in   [STAGES];
  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] nb_in   [STAGES];
  logic [WIDTH-1:0] diff_in [STAGES];
  logic [WIDTH-1:0] diff_nx [STAGES];
  logic             c_nx    [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[k]  = in_valid;
      assign a_in[k]    = a;
      assign nb_in[k]   = ~b;
      assign diff_in[k] = '0;
      assign c_in[k]    = ~bin;
      assign am_in[k]   = a[WIDTH-1];
      assign bm_in[k]   = b[WIDTH-1];
    end else begin : g_body
      assign vld_in[k]  = ctl_p[k-1].vld;
      assign a_in[k]    = a_p[k-1];
      assign nb_in[k]   = nb_p[k-1];
      assign diff_in[k] = diff_p[k-1];
      assign c_in[k]    = ctl_p[k-1].carry;
      assign am_in[k]   = ctl_p[k-1].a_msb;
      assign bm_in[k]   = ctl_p[k-1].b_msb;
    end

    logic [SW-1:0] sum_s;

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
      logic ci;
      logic co;
      if (s == 0) begin : g_cin0
        assign ci = c_in[k];
      end else begin : g_cinn
        assign ci = g_seg[s-1].co;
      end
      bypass_sub_segment #(.SEG_W(SEG_W)) u_seg (
        .a    (a_in[k][k*SW + s*SEG_W +: SEG_W]),
        .nb   (nb_in[k][k*SW + s*SEG_W +: SEG_W]),
        .cin  (ci),
        .sum  (sum_s[s*SEG_W +: SEG_W]),
        .cout (co)
      );
    end

    // Unresolved diff bits stay zero, so OR-ing in this slice's sum is exact.
    assign diff_nx[k] = diff_in[k] | (WIDTH'(sum_s) << (k*SW));
    assign c_nx[k]    = g_seg[NSEG-1].co;
  end

  // Stage registers: control plus the final-stage outputs, which must reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        ctl_p[k] <= '0;
      end
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        ctl_p[k] <= '{vld: vld_in[k], carry: c_nx[k], a_msb: am_in[k], b_msb: bm_in[k]};
      end
      out_valid <= vld_in[LAST];
      diff      <= diff_nx[LAST];
      bout      <= ~c_nx[LAST];
      overflow  <= (am_in[LAST] != bm_in[LAST]) && (diff_nx[LAST][WIDTH-1] != am_in[LAST]);
    end
  end

  // Stage registers: intermediate operand skew and partial diff, qualified by vld.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_p[k]    <= a_in[k];
        nb_p[k]   <= nb_in[k];
        diff_p[k] <= diff_nx[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bypass_subtractor.sv
// Self-checking bench for pipelined_bypass_subtractor: scoreboard of expected
// results, directed vectors, backpressure stream and mid-operation reset.
module tb_pipelined_bypass_subtractor;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               tick;
    logic             lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tcnt   = 0;
  int   npop   = 0;
  int   pc     = 0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] snap_diff;
  logic             snap_bout;
  logic             snap_ovf;

  always #5 clk = ~clk;

  pipelined_bypass_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES), .SEG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tbin);
    exp_t        e;
    logic [WIDTH:0] r;
    r      = {1'b0, ta} - {1'b0, tb} - {{WIDTH{1'b0}}, tbin};
    e.diff = r[WIDTH-1:0];
    e.bout = r[WIDTH];
    e.ovf  = (ta[WIDTH-1] != tb[WIDTH-1]) && (r[WIDTH-1] != ta[WIDTH-1]);
    e.tick = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  // One clock: drive at negedge, settle, then account for the transfers that
  // the following posedge will perform.
  task automatic tick(input logic v, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic tbin, input logic ordy, input logic lat, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb;
    bin       = tbin;
    out_ready = ordy;
    #1;
    tcnt++;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", diff, snap_diff);
      chk("hold_bout", bout, snap_bout);
      chk("hold_ovf", overflow, snap_ovf);
    end
    stall_prev = out_valid && !out_ready;
    snap_diff  = diff;
    snap_bout  = bout;
    snap_ovf   = overflow;
    acc = in_valid && in_ready;
    if (acc) begin
      e      = model(ta, tb, tbin);
      e.tick = tcnt;
      e.lat  = lat;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", diff);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        npop++;
        chk("diff", diff, e.diff);
        chk("bout", bout, e.bout);
        chk("overflow", overflow, e.ovf);
        if (e.lat) chk("latency", tcnt - e.tick, STAGES);
      end
    end
  endtask

  task automatic drain(input logic bp);
    logic acc;
    for (int n = 0; n < 80 && q.size() > 0; n++) begin
      tick(1'b0, '0, '0, 1'b0, bp ? (pc % 3 == 0) : 1'b1, 1'b0, acc);
      pc++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send1(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
    logic acc;
    tick(1'b1, ta, tb, tbin, 1'b1, 1'b1, acc);
    chk("accept", acc, 1);
    drain(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   i;
    int   npop0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    send1(32'd5, 32'd3, 1'b0);
    send1(32'd0, 32'd1, 1'b0);
    send1(32'h8000_0000, 32'd1, 1'b0);
    send1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send1(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send1(32'h0000_0010, 32'h0000_000F, 1'b1);

    for (int n = 0; n < 8; n++) begin
      tick(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
    end
    drain(1'b0);

    npop0 = npop;
    i     = 0;
    pc    = 0;
    for (int n = 0; n < 120 && i < 8; n++) begin
      tick(1'b1, WIDTH'(i + 10), WIDTH'(i), 1'b0, (pc % 3 == 0), 1'b0, acc);
      pc++;
      if (acc) i++;
    end
    chk("bp_accepted", i, 8);
    drain(1'b1);
    chk("bp_count", npop - npop0, 8);

    for (int n = 0; n < 3; n++) begin
      tick(1'b1, WIDTH'(100 + n), WIDTH'(n), 1'b0, 1'b0, 1'b0, acc);
    end
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_diff", diff, 100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_diff", diff, 0);
    chk("async_rst_bout", bout, 0);
    chk("async_rst_ovf", overflow, 0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    chk("in_rst_valid", out_valid, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 6; n++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      chk("no_stale_beat", out_valid, 0);
    end
    send1(32'h0000_1234, 32'h0000_0034, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
